// File: rtl/glip_cypressfx3_pkg.sv
// Shared constants for the FX3 slave-FIFO emulator and the FPGA-side interface.
package glip_cypressfx3_pkg;

  typedef logic [1:0] fx3_addr_t;

  localparam fx3_addr_t FX3_EPIN  = 2'b00;
  localparam fx3_addr_t FX3_EPOUT = 2'b11;

  localparam int unsigned PERR_W        = 4;
  localparam int unsigned PERR_RD_EMPTY = 0;
  localparam int unsigned PERR_WR_FULL  = 1;
  localparam int unsigned PERR_RD_WR    = 2;
  localparam int unsigned PERR_BAD_ADDR = 3;

  // True when the address selects one of the two emulated endpoints.
  function automatic logic fx3_is_ep(input fx3_addr_t a);
    return (a == FX3_EPIN) || (a == FX3_EPOUT);
  endfunction

endpackage

// File: rtl/glip_cypressfx3_emu_fifo.sv
// Synchronous FIFO with occupancy output and an optional tail-MSB tag write.
module glip_cypressfx3_emu_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  input  logic                     i_tag_tail,
  output logic [WIDTH-1:0]         o_head_c,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_tail_ptr;

  assign w_push_ok     = i_push && (o_count != CW'(DEPTH));
  assign w_pop_ok      = i_pop && (o_count != '0);
  assign w_tail_ptr    = r_wr_ptr - AW'(1);
  assign o_count_nxt_c = o_count + CW'(w_push_ok) - CW'(w_pop_ok);
  assign o_head_c      = r_mem[r_rd_ptr];

  // Pointers and occupancy; pointer wrap relies on power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      o_count <= o_count_nxt_c;
    end
  end

  // Storage; tag write targets the tail entry, never the one being pushed.
  always_ff @(posedge clk) begin
    if (w_push_ok)  r_mem[r_wr_ptr] <= i_din;
    if (i_tag_tail) r_mem[w_tail_ptr][WIDTH-1] <= 1'b1;
  end

endmodule

// File: rtl/glip_cypressfx3_slave_emu.sv
// Cypress FX3 slave-FIFO emulator: host streams on one side, FX3 pins on the other.
// Optional protocol checker enabled by defining GLIP_FX3_EMU_PROTO_CHECK_EN.
module glip_cypressfx3_slave_emu
  import glip_cypressfx3_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned OUT_DEPTH     = 64,
  parameter int unsigned IN_DEPTH      = 64,
  parameter int unsigned ALMOST_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [WIDTH-1:0]  fx3_dq,
  input  logic              fx3_slcs_n,
  input  logic              fx3_sloe_n,
  input  logic              fx3_slrd_n,
  input  logic              fx3_slwr_n,
  input  logic              fx3_pktend_n,
  input  logic [1:0]        fx3_a,
  output logic              fx3_flaga,
  output logic              fx3_flagb,
  output logic              fx3_flagc,
  output logic              fx3_flagd,
  output logic              fx3_com_rst,
  output logic              fx3_logic_rst,
  input  logic              host_out_valid,
  output logic              host_out_ready,
  input  logic [WIDTH-1:0]  host_out_data,
  output logic              host_in_valid,
  input  logic              host_in_ready,
  output logic [WIDTH-1:0]  host_in_data,
  output logic              host_in_last,
  output logic              host_in_zlp,
  input  logic              host_com_rst,
  input  logic              host_logic_rst,
  output logic [PERR_W-1:0] proto_err
);

  localparam int unsigned OCW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned ICW = $clog2(IN_DEPTH) + 1;

  logic           w_cs;
  logic           w_rd_req;
  logic           w_wr_req;
  logic           w_pktend_only;
  logic           w_out_pop_ok;
  logic           w_in_push_ok;
  logic           w_in_pop;
  logic           w_tail_open;
  logic           w_tag_tail;
  logic           w_dq_oe;
  logic [WIDTH-1:0] w_out_head;
  logic [WIDTH:0]   w_in_head;
  logic [OCW-1:0] w_out_cnt;
  logic [OCW-1:0] w_out_cnt_nxt;
  logic [ICW-1:0] w_in_cnt;
  logic [ICW-1:0] w_in_cnt_nxt;
  logic           r_in_tail_tagged;
  logic [WIDTH-1:0] r_rd_s0;
  logic [WIDTH-1:0] r_rd_s1;
  logic [WIDTH-1:0] r_rd_s2;

  assign w_cs          = !fx3_slcs_n;
  assign w_rd_req      = w_cs && !fx3_slrd_n && (fx3_a == FX3_EPOUT);
  assign w_wr_req      = w_cs && !fx3_slwr_n && (fx3_a == FX3_EPIN);
  assign w_pktend_only = w_cs && !fx3_pktend_n && fx3_slwr_n && (fx3_a == FX3_EPIN);
  assign w_out_pop_ok  = w_rd_req && (w_out_cnt != '0);
  assign w_in_push_ok  = w_wr_req && (w_in_cnt != ICW'(IN_DEPTH));
  assign w_in_pop      = host_in_valid && host_in_ready;

  // A tail word leaving this cycle is no longer taggable.
  assign w_tail_open   = (w_in_cnt != '0) && !r_in_tail_tagged &&
                         !(w_in_pop && (w_in_cnt == ICW'(1)));
  assign w_tag_tail    = w_pktend_only && w_tail_open;

  assign host_in_data  = w_in_head[WIDTH-1:0];
  assign host_in_last  = w_in_head[WIDTH];

  // Pins are released during reset and whenever the master is writing.
  assign w_dq_oe = !rst && w_cs && !fx3_sloe_n && fx3_slwr_n;
  assign fx3_dq  = w_dq_oe ? r_rd_s2 : 'z;

  glip_cypressfx3_emu_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (host_out_valid && host_out_ready),
    .i_din         (host_out_data),
    .i_pop         (w_rd_req),
    .i_tag_tail    (1'b0),
    .o_head_c      (w_out_head),
    .o_count       (w_out_cnt),
    .o_count_nxt_c (w_out_cnt_nxt)
  );

  glip_cypressfx3_emu_fifo #(.WIDTH(WIDTH + 1), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_wr_req),
    .i_din         ({!fx3_pktend_n, fx3_dq}),
    .i_pop         (w_in_pop),
    .i_tag_tail    (w_tag_tail),
    .o_head_c      (w_in_head),
    .o_count       (w_in_cnt),
    .o_count_nxt_c (w_in_cnt_nxt)
  );

  // Tracks whether the newest IN word already carries a packet-end tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_in_tail_tagged <= 1'b1;
    else if (w_in_push_ok) r_in_tail_tagged <= !fx3_pktend_n;
    else if (w_tag_tail)   r_in_tail_tagged <= 1'b1;
  end

  // Read pipeline: fetch on pop, then two stages to the pins; holds on dropped pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_s0 <= '0;
      r_rd_s1 <= '0;
      r_rd_s2 <= '0;
    end else begin
      if (w_out_pop_ok) r_rd_s0 <= w_out_head;
      r_rd_s1 <= r_rd_s0;
      r_rd_s2 <= r_rd_s1;
    end
  end

  // Flags, stream handshakes and reset forwarding reflect occupancy after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fx3_flaga      <= 1'b1;
      fx3_flagb      <= 1'b1;
      fx3_flagc      <= 1'b0;
      fx3_flagd      <= 1'b0;
      host_out_ready <= 1'b0;
      host_in_valid  <= 1'b0;
      host_in_zlp    <= 1'b0;
      fx3_com_rst    <= 1'b1;
      fx3_logic_rst  <= 1'b1;
    end else begin
      fx3_flaga      <= w_in_cnt_nxt != ICW'(IN_DEPTH);
      fx3_flagb      <= (ICW'(IN_DEPTH) - w_in_cnt_nxt) > ICW'(ALMOST_THRESH);
      fx3_flagc      <= w_out_cnt_nxt != '0;
      fx3_flagd      <= w_out_cnt_nxt > OCW'(ALMOST_THRESH);
      host_out_ready <= w_out_cnt_nxt != OCW'(OUT_DEPTH);
      host_in_valid  <= w_in_cnt_nxt != '0;
      host_in_zlp    <= w_pktend_only && !w_tail_open;
      fx3_com_rst    <= host_com_rst;
      fx3_logic_rst  <= host_logic_rst;
    end
  end

`ifdef GLIP_FX3_EMU_PROTO_CHECK_EN
  logic [PERR_W-1:0] w_err_set;

  // Classify master protocol violations for this cycle.
  always_comb begin
    w_err_set = '0;
    w_err_set[PERR_RD_EMPTY] = w_rd_req && (w_out_cnt == '0);
    w_err_set[PERR_WR_FULL]  = w_wr_req && (w_in_cnt == ICW'(IN_DEPTH));
    w_err_set[PERR_RD_WR]    = w_cs && !fx3_slrd_n && !fx3_slwr_n;
    w_err_set[PERR_BAD_ADDR] = w_cs && (!fx3_slrd_n || !fx3_slwr_n || !fx3_pktend_n) &&
                               !fx3_is_ep(fx3_a);
  end

  // Sticky error bits, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= '0;
    else     proto_err <= proto_err | w_err_set;
  end
`else
  assign proto_err = '0;
`endif

endmodule

// File: tb/tb_glip_cypressfx3_slave_emu.sv
// Directed bench for glip_cypressfx3_slave_emu (default parameters).
module tb_glip_cypressfx3_slave_emu;

`ifdef GLIP_FX3_EMU_PROTO_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] HIZ = 32'h0000_FFFF;

  logic        clk;
  logic        rst;
  wire  [15:0] fx3_dq;
  logic        fx3_slcs_n, fx3_sloe_n, fx3_slrd_n, fx3_slwr_n, fx3_pktend_n;
  logic [1:0]  fx3_a;
  logic        fx3_flaga, fx3_flagb, fx3_flagc, fx3_flagd;
  logic        fx3_com_rst, fx3_logic_rst;
  logic        host_out_valid, host_out_ready;
  logic [15:0] host_out_data;
  logic        host_in_valid, host_in_ready, host_in_last, host_in_zlp;
  logic [15:0] host_in_data;
  logic        host_com_rst, host_logic_rst;
  logic [3:0]  proto_err;
  logic        dq_oe;
  logic [15:0] dq_drv;
  logic [3:0]  exp_err;

  int total = 0;
  int bad   = 0;

  assign fx3_dq = dq_oe ? dq_drv : 'z;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (fx3_dq[g]);
  end

  glip_cypressfx3_slave_emu dut (
    .clk(clk), .rst(rst), .fx3_dq(fx3_dq),
    .fx3_slcs_n(fx3_slcs_n), .fx3_sloe_n(fx3_sloe_n), .fx3_slrd_n(fx3_slrd_n),
    .fx3_slwr_n(fx3_slwr_n), .fx3_pktend_n(fx3_pktend_n), .fx3_a(fx3_a),
    .fx3_flaga(fx3_flaga), .fx3_flagb(fx3_flagb), .fx3_flagc(fx3_flagc), .fx3_flagd(fx3_flagd),
    .fx3_com_rst(fx3_com_rst), .fx3_logic_rst(fx3_logic_rst),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_data(host_out_data),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .host_in_last(host_in_last), .host_in_zlp(host_in_zlp),
    .host_com_rst(host_com_rst), .host_logic_rst(host_logic_rst), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; fx3_slcs_n = 1'b0; fx3_sloe_n = 1'b1; fx3_slrd_n = 1'b1;
    fx3_slwr_n = 1'b1; fx3_pktend_n = 1'b1; fx3_a = 2'b11; dq_oe = 1'b0; dq_drv = '0;
    host_out_valid = 1'b0; host_out_data = '0; host_in_ready = 1'b0;
    host_com_rst = 1'b0; host_logic_rst = 1'b0;
    exp_err = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_flaga", 32'(fx3_flaga), 32'd1);
    chk("rst_flagb", 32'(fx3_flagb), 32'd1);
    chk("rst_flagc", 32'(fx3_flagc), 32'd0);
    chk("rst_flagd", 32'(fx3_flagd), 32'd0);
    chk("rst_out_ready", 32'(host_out_ready), 32'd0);
    chk("rst_in_valid", 32'(host_in_valid), 32'd0);
    chk("rst_zlp", 32'(host_in_zlp), 32'd0);
    chk("rst_com_rst", 32'(fx3_com_rst), 32'd1);
    chk("rst_logic_rst", 32'(fx3_logic_rst), 32'd1);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_dq_hiz", 32'(fx3_dq), HIZ);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_ready", 32'(host_out_ready), 32'd1);
    chk("post_rst_com_rst", 32'(fx3_com_rst), 32'd0);
    chk("post_rst_logic_rst", 32'(fx3_logic_rst), 32'd0);

    // Reset forwarding, one cycle latency
    host_com_rst = 1'b1;
    @(negedge clk);
    chk("fwd_com_rst", 32'(fx3_com_rst), 32'd1);
    chk("fwd_logic_idle", 32'(fx3_logic_rst), 32'd0);
    host_com_rst = 1'b0; host_logic_rst = 1'b1;
    @(negedge clk);
    chk("fwd_com_rel", 32'(fx3_com_rst), 32'd0);
    chk("fwd_logic_rst", 32'(fx3_logic_rst), 32'd1);
    host_logic_rst = 1'b0;

    // Host pushes 1..5 into OUT, then FX3 reads a burst of five
    host_out_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      host_out_data = 16'(i);
      @(negedge clk);
    end
    host_out_valid = 1'b0;
    chk("out5_flagc", 32'(fx3_flagc), 32'd1);
    chk("out5_flagd", 32'(fx3_flagd), 32'd1);
    fx3_sloe_n = 1'b0; fx3_slrd_n = 1'b0; fx3_a = 2'b11;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("burst_dq", 32'(fx3_dq), (c < 2) ? 32'd0 : ((c < 6) ? 32'(c - 1) : 32'd5));
      chk("burst_flagc", 32'(fx3_flagc), (c < 4) ? 32'd1 : 32'd0);
      if (c == 0) chk("burst_flagd_at4", 32'(fx3_flagd), 32'd0);
      if (c == 4) fx3_slrd_n = 1'b1;
    end

    // Read on empty OUT is dropped, pipeline holds
    fx3_slrd_n = 1'b0;
    @(negedge clk);
    fx3_slrd_n = 1'b1;
    repeat (3) @(negedge clk);
    if (CHK) exp_err[0] = 1'b1;
    chk("empty_rd_dq_hold", 32'(fx3_dq), 32'd5);
    chk("empty_rd_flagc", 32'(fx3_flagc), 32'd0);
    chk("empty_rd_err", 32'(proto_err), 32'(exp_err));
    fx3_sloe_n = 1'b1;
    @(negedge clk);
    chk("sloe_release_hiz", 32'(fx3_dq), HIZ);

    // Three-word packet A0,A1,A2 with pktend on the last
    fx3_a = 2'b00; dq_oe = 1'b1; fx3_slwr_n = 1'b0; dq_drv = 16'h00A0;
    @(negedge clk);
    dq_drv = 16'h00A1;
    @(negedge clk);
    dq_drv = 16'h00A2; fx3_pktend_n = 1'b0;
    @(negedge clk);
    fx3_slwr_n = 1'b1; fx3_pktend_n = 1'b1; dq_oe = 1'b0;
    chk("pkt_valid", 32'(host_in_valid), 32'd1);
    chk("pkt_zlp", 32'(host_in_zlp), 32'd0);
    host_in_ready = 1'b1;
    chk("pkt_w0", {15'd0, host_in_last, host_in_data}, 32'h0000_00A0);
    @(negedge clk);
    chk("pkt_w1", {15'd0, host_in_last, host_in_data}, 32'h0000_00A1);
    @(negedge clk);
    chk("pkt_w2", {15'd0, host_in_last, host_in_data}, 32'h0001_00A2);
    @(negedge clk);
    chk("pkt_drained", 32'(host_in_valid), 32'd0);
    host_in_ready = 1'b0;

    // Standalone pktend tags an untagged tail word instead of a ZLP
    fx3_slwr_n = 1'b0; dq_oe = 1'b1; dq_drv = 16'h00B0;
    @(negedge clk);
    fx3_slwr_n = 1'b1; dq_oe = 1'b0; fx3_pktend_n = 1'b0;
    @(negedge clk);
    fx3_pktend_n = 1'b1;
    chk("tail_tag_zlp", 32'(host_in_zlp), 32'd0);
    chk("tail_tag_word", {15'd0, host_in_last, host_in_data}, 32'h0001_00B0);
    host_in_ready = 1'b1;
    @(negedge clk);
    chk("tail_tag_drained", 32'(host_in_valid), 32'd0);
    host_in_ready = 1'b0;

    // Standalone pktend on empty IN -> single-cycle ZLP
    fx3_pktend_n = 1'b0;
    @(negedge clk);
    fx3_pktend_n = 1'b1;
    chk("zlp_pulse", 32'(host_in_zlp), 32'd1);
    chk("zlp_valid", 32'(host_in_valid), 32'd0);
    @(negedge clk);
    chk("zlp_end", 32'(host_in_zlp), 32'd0);
    chk("zlp_valid2", 32'(host_in_valid), 32'd0);

    // Fill IN to 64, then one dropped write
    dq_oe = 1'b1;
    for (int i = 0; i < 65; i++) begin
      dq_drv = 16'h1000 + 16'(i);
      fx3_slwr_n = 1'b0;
      @(negedge clk);
      chk("fill_flaga", 32'(fx3_flaga), (i < 63) ? 32'd1 : 32'd0);
      chk("fill_flagb", 32'(fx3_flagb), (i < 59) ? 32'd1 : 32'd0);
    end
    fx3_slwr_n = 1'b1; dq_oe = 1'b0;
    if (CHK) exp_err[1] = 1'b1;
    chk("full_wr_err", 32'(proto_err), 32'(exp_err));
    host_in_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("drain_word", {15'd0, host_in_last, host_in_data}, 32'h1000 + 32'(i));
      @(negedge clk);
    end
    chk("drain_done", 32'(host_in_valid), 32'd0);
    host_in_ready = 1'b0;

    // Reset asserted in the middle of a ten-word read burst
    host_out_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_out_data = 16'h2000 + 16'(i);
      @(negedge clk);
    end
    host_out_valid = 1'b0;
    chk("out10_flagd", 32'(fx3_flagd), 32'd1);
    fx3_a = 2'b11; fx3_sloe_n = 1'b0; fx3_slrd_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midburst_dq", 32'(fx3_dq), 32'h2000);
    #2 rst = 1'b1;
    #1;
    chk("midrst_flagc", 32'(fx3_flagc), 32'd0);
    chk("midrst_dq_hiz", 32'(fx3_dq), HIZ);
    chk("midrst_out_ready", 32'(host_out_ready), 32'd0);
    chk("midrst_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    fx3_slrd_n = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("postrst_dq", 32'(fx3_dq), 32'd0);
      chk("postrst_flagc", 32'(fx3_flagc), 32'd0);
    end
    fx3_sloe_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
